// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// The decode is combinational on the inputs. The result goes into a 2-entry
// buffer: an output register O and a skid register S, drained in FIFO order.
// in_ready comes only from registered state, so there is no combinational path
// from out_ready to in_ready.
// Optional feature: define IMM_GEN_ERRCNT_EN to add the err_count output. It is
// a saturating count of delivered items that carry out_err=1.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_err,
`ifdef IMM_GEN_ERRCNT_EN
    output logic [15:0]      err_count,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_J    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] SEL_AUTO = 3'b101;
    localparam logic [2:0] FMT_Z    = 3'b110;
    localparam logic [2:0] FMT_NONE = 3'b111;

    logic [6:0]        opc;
    logic [2:0]        auto_fmt;
    logic              auto_err;
    logic [2:0]        dec_fmt;
    logic              dec_err;
    logic [XLEN-1:0]   dec_imm;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;

    logic              o_valid, s_valid;
    logic [XLEN-1:0]   o_imm, s_imm;
    logic [2:0]        o_fmt, s_fmt;
    logic              o_err, s_err;
    logic [TAG_W-1:0]  o_tag, s_tag;
    logic              accept, drain;

    assign opc   = in_instr[6:0];
    assign imm_i = in_instr[31:20];
    assign imm_s = {in_instr[31:25], in_instr[11:7]};
    assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};

    // Opcode to format map used when the select is AUTO
    always_comb begin
        auto_fmt = FMT_NONE;
        auto_err = 1'b1;
        case (opc)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
                auto_fmt = FMT_I;
                auto_err = 1'b0;
            end
            7'b0100011: begin
                auto_fmt = FMT_S;
                auto_err = 1'b0;
            end
            7'b1100011: begin
                auto_fmt = FMT_B;
                auto_err = 1'b0;
            end
            7'b1101111: begin
                auto_fmt = FMT_J;
                auto_err = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                auto_fmt = FMT_U;
                auto_err = 1'b0;
            end
            // SYSTEM: funct3[2] set means a CSR immediate form
            7'b1110011: begin
                auto_fmt = in_instr[14] ? FMT_Z : FMT_I;
                auto_err = 1'b0;
            end
            // R-type ops legitimately carry no immediate
            7'b0110011, 7'b0111011: begin
                auto_err = 1'b0;
            end
            default: ;
        endcase
    end

    // Resolve the final format and the error flag from the select
    always_comb begin
        dec_fmt = in_immsrc;
        dec_err = 1'b0;
        if (in_immsrc == SEL_AUTO) begin
            dec_fmt = auto_fmt;
            dec_err = auto_err;
        end else if (in_immsrc == FMT_NONE) begin
            dec_err = 1'b1;
        end
    end

    // Build the extended immediate for the resolved format
    always_comb begin
        dec_imm = '0;
        case (dec_fmt)
            FMT_I:   dec_imm = XLEN'(imm_i);
            FMT_S:   dec_imm = XLEN'(imm_s);
            FMT_B:   dec_imm = XLEN'(imm_b);
            FMT_J:   dec_imm = XLEN'(imm_j);
            FMT_U:   dec_imm = XLEN'(imm_u);
            FMT_Z:   dec_imm = XLEN'(in_instr[19:15]);
            default: dec_imm = '0;
        endcase
    end

    assign in_ready = !s_valid;
    assign accept   = in_valid && !s_valid;
    assign drain    = o_valid && out_ready;

    // O/S buffer. S is only occupied while O is occupied, so it always refills O first
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            o_imm   <= '0;
            o_fmt   <= '0;
            o_err   <= 1'b0;
            o_tag   <= '0;
            s_imm   <= '0;
            s_fmt   <= '0;
            s_err   <= 1'b0;
            s_tag   <= '0;
        end else if (!o_valid || drain) begin
            if (s_valid) begin
                o_valid <= 1'b1;
                o_imm   <= s_imm;
                o_fmt   <= s_fmt;
                o_err   <= s_err;
                o_tag   <= s_tag;
                s_valid <= 1'b0;
            end else if (accept) begin
                o_valid <= 1'b1;
                o_imm   <= dec_imm;
                o_fmt   <= dec_fmt;
                o_err   <= dec_err;
                o_tag   <= in_tag;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_imm   <= dec_imm;
            s_fmt   <= dec_fmt;
            s_err   <= dec_err;
            s_tag   <= in_tag;
        end
    end

    assign out_valid = o_valid;
    assign out_imm   = o_imm;
    assign out_fmt   = o_fmt;
    assign out_err   = o_err;
    assign out_tag   = o_tag;

`ifdef IMM_GEN_ERRCNT_EN
    logic [15:0] err_cnt;

    // Saturating count of delivered items that are flagged as errors
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (drain && o_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_count = err_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: a scoreboard of expected items, checked in order.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             err;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_GEN_ERRCNT_EN
    logic [15:0]      err_count;
`endif

    item_t sb[$];
    int    out_cycs[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_out  = 0;
    int    cyc    = 0;
    int    n0;
    bit    rand_rdy = 1'b0;
    item_t mon_e;

    logic [6:0] ops [0:12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F,
                               7'h37, 7'h17, 7'h73, 7'h33, 7'h3B, 7'h7F};

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_immsrc (in_immsrc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_err   (out_err),
`ifdef IMM_GEN_ERRCNT_EN
        .err_count (err_count),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic item_t mk(input logic [XLEN-1:0] imm, input logic [2:0] f,
                                 input logic e, input logic [TAG_W-1:0] t);
        item_t r;
        r.imm = imm;
        r.fmt = f;
        r.err = e;
        r.tag = t;
        return r;
    endfunction

    // Reference model: shifts a sign-extended copy of the word into place
    function automatic item_t model(input logic [31:0] ins, input logic [2:0] src,
                                    input logic [TAG_W-1:0] t);
        logic signed [63:0] sx;
        logic [63:0] v;
        logic [2:0]  f;
        logic        e;
        sx = {{32{ins[31]}}, ins};
        f  = src;
        e  = 1'b0;
        if (src == 3'd5) begin
            case (ins[6:0])
                7'h13, 7'h03, 7'h67, 7'h1B: f = 3'd0;
                7'h23: f = 3'd1;
                7'h63: f = 3'd2;
                7'h6F: f = 3'd3;
                7'h37, 7'h17: f = 3'd4;
                7'h73: f = ins[14] ? 3'd6 : 3'd0;
                7'h33, 7'h3B: f = 3'd7;
                default: begin f = 3'd7; e = 1'b1; end
            endcase
        end else if (src == 3'd7) begin
            e = 1'b1;
        end
        case (f)
            3'd0: v = sx >>> 20;
            3'd1: v = ((sx >>> 25) << 5) | 64'(ins[11:7]);
            3'd2: v = ((sx >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                      | (64'(ins[11:8]) << 1);
            3'd3: v = ((sx >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                      | (64'(ins[30:21]) << 1);
            3'd4: v = sx & ~64'hFFF;
            3'd6: v = 64'(ins[19:15]);
            default: v = 64'd0;
        endcase
        return mk(v[XLEN-1:0], f, e, t);
    endfunction

    // Offer one item, push its expectation when the handshake will complete
    task automatic send(input logic [31:0] ins, input logic [2:0] src,
                        input logic [TAG_W-1:0] t, input item_t exp);
        bit done = 1'b0;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
        in_tag    = t;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: every delivered item must match the oldest expectation
    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_out++;
            out_cycs.push_back(cyc);
            chk("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("imm", 64'(out_imm), 64'(mon_e.imm));
                chk("fmt", 64'(out_fmt), 64'(mon_e.fmt));
                chk("err", 64'(out_err), 64'(mon_e.err));
                chk("tag", 64'(out_tag), 64'(mon_e.tag));
            end
        end
    end

    // Random backpressure during the random phase
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        logic [2:0]  src;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_imm",       64'(out_imm),   64'd0);
        chk("rst_fmt",       64'(out_fmt),   64'd0);
        chk("rst_err",       64'(out_err),   64'd0);
        chk("rst_tag",       64'(out_tag),   64'd0);
`ifdef IMM_GEN_ERRCNT_EN
        chk("rst_err_count", 64'(err_count), 64'd0);
`endif
        @(posedge clk);
        #1;

        // addi x1,x0,-1 in AUTO mode, latency 1
        send(32'hFFF00093, 3'd5, 5'd1, mk('1, 3'd0, 1'b0, 5'd1));
        @(negedge clk);
        chk("lat1_valid", 64'(out_valid), 64'd1);
        chk("lat1_tag",   64'(out_tag),   64'd1);
        @(posedge clk);
        #1;
        idle(2);

        // back-to-back sw, lui, jal
        out_cycs.delete();
        send(32'hFE112E23, 3'd5, 5'd2, mk(32'hFFFFFFFC, 3'd1, 1'b0, 5'd2));
        send(32'h123452B7, 3'd5, 5'd3, mk(32'h12345000, 3'd4, 1'b0, 5'd3));
        send(32'h001000EF, 3'd5, 5'd4, mk(32'h00000800, 3'd3, 1'b0, 5'd4));
        idle(3);
        chk("b2b_count", 64'(out_cycs.size()), 64'd3);
        if (out_cycs.size() == 3) begin
            chk("b2b_gap1", 64'(out_cycs[1] - out_cycs[0]), 64'd1);
            chk("b2b_gap2", 64'(out_cycs[2] - out_cycs[1]), 64'd1);
        end

        // no-immediate and error cases
        send(32'h002081B3, 3'd5, 5'd5, mk('0, 3'd7, 1'b0, 5'd5));
        send(32'h0000007F, 3'd5, 5'd6, mk('0, 3'd7, 1'b1, 5'd6));
        send(32'hFFF00093, 3'd7, 5'd7, mk('0, 3'd7, 1'b1, 5'd7));
        idle(3);
`ifdef IMM_GEN_ERRCNT_EN
        chk("err_count2", 64'(err_count), 64'd2);
`endif

        // backpressure: two accepted, third held until out_ready rises
        out_ready = 1'b0;
        n0 = n_out;
        send(32'h00100093, 3'd5, 5'd1, mk(32'd1, 3'd0, 1'b0, 5'd1));
        send(32'h00200093, 3'd5, 5'd2, mk(32'd2, 3'd0, 1'b0, 5'd2));
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_instr  = 32'h00300093;
        in_immsrc = 3'd5;
        in_tag    = 5'd3;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_tag",    64'(out_tag),  64'd1);
            chk("bp_hold_imm",    64'(out_imm),  64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h00300093, 3'd5, 5'd3, mk(32'd3, 3'd0, 1'b0, 5'd3));
        idle(4);
        chk("bp_delivered", 64'(n_out - n0), 64'd3);

        // explicit CSR immediate
        send(32'h000F8000, 3'd6, 5'd8, mk(32'h0000001F, 3'd6, 1'b0, 5'd8));
        // explicit B with negative offset and SYSTEM resolving to I
        send(32'hFE000FE3, 3'd2, 5'd9, mk(32'hFFFFFFFE, 3'd2, 1'b0, 5'd9));
        send(32'h30001073, 3'd5, 5'd10, mk(32'h00000300, 3'd0, 1'b0, 5'd10));
        idle(3);

        // random items under random backpressure, checked against the model
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            src = 3'($urandom_range(0, 7));
            ins[6:0] = ops[$urandom_range(0, 12)];
            send(ins, src, TAG_W'(i), model(ins, src, TAG_W'(i)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
        chk("rand_drained", 64'(sb.size()), 64'd0);

        // reset with both entries full
        out_ready = 1'b0;
        send(32'h00500093, 3'd5, 5'd11, mk(32'd5, 3'd0, 1'b0, 5'd11));
        send(32'h0000007F, 3'd5, 5'd12, mk('0, 3'd7, 1'b1, 5'd12));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready",  64'(in_ready),  64'd1);
`ifdef IMM_GEN_ERRCNT_EN
        chk("rst2_err_count", 64'(err_count), 64'd0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n0 = n_out;
        idle(5);
        chk("rst2_no_stale", 64'(n_out - n0), 64'd0);

        send(32'h80000037, 3'd4, 5'd13, mk(32'h80000000, 3'd4, 1'b0, 5'd13));
        idle(3);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined RISC-V immediate generator.
- Accepts an instruction word plus a format select (explicit or auto-decoded from the opcode) over a valid/ready handshake.
- Produces an XLEN-wide extended immediate, a format code and an error flag, with 1-cycle latency and full throughput.
- Sits between fetch/decode and execute operand muxing; a 2-entry skid buffer absorbs execute-side backpressure.

Parameters:
- XLEN, 32: output immediate width; legal values are 32 and 64.
- TAG_W, 5: width of the sideband tag passed through unchanged with each instruction (e.g. rd or ROB id).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream item valid
- in_ready  output  1  block can accept an item this cycle
- in_instr  input  32  full instruction word
- in_immsrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 AUTO, 110 Z (CSR zimm), 111 illegal
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  output item valid
- out_ready  input  1  downstream accepts the item
- out_imm  output  XLEN  extended immediate
- out_fmt  output  3  resolved format (000–100 as above, 110 Z, 111 none)
- out_err  output  1  illegal select or unknown opcode
- out_tag  output  TAG_W  tag of the item on the output

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - out_valid=0.
  - Both buffer entries empty; their contents are don't-care.
  - in_ready=1 from the first cycle after reset is released.
  - out_imm, out_fmt, out_tag are 0.
  - out_err=0.
- Storage: output register (O) plus skid register (S), delivered in FIFO order.
  - in_ready = !S.valid, taken from registered state only; no combinational path from out_ready.
  - Accept occurs when in_valid && in_ready. Decode is combinational on the inputs, and the result is registered.
  - Accept, and O is empty or O drains this cycle: the item loads into O. out_valid is asserted in the next cycle (latency 1).
  - Accept while O is held (out_valid && !out_ready): the item loads into S.
  - O drains and S is full: S moves to O, and S becomes empty.
  - Accept and drain in the same cycle: sustained throughput of 1 item/cycle.
- Output stability: O is held stable while out_valid && !out_ready.
- Format extraction (instr=in_instr):
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}, sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN (matters when XLEN=64).
  - Z: instr[19:15], zero-extended.
- AUTO mode maps opcode instr[6:0] to a format:
  - I: 0010011, 0000011, 1100111, 0011011.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0110111, 0010111.
  - Z: 1110011 with funct3[2]=1. SYSTEM with funct3[2]=0 resolves to I.
  - None: 0110011, 0111011 → imm=0, fmt=111, err=0.
  - Any other opcode → imm=0, fmt=111, err=1.
- Explicit select 111 → imm=0, fmt=111, err=1.
- out_fmt always reports the resolved format, never 101.
- Reset mid-operation: all entries are discarded and out_valid=0 in the following cycle. No partial item is ever emitted.
- in_valid=0 with in_ready=1: no state change.

Optional Feature:
- Macro IMM_GEN_ERRCNT_EN.
- When defined, adds output port err_count [15:0]:
  - Increments once per item that is delivered (out_valid && out_ready) with out_err=1.
  - Saturates at 0xFFFF.
  - Cleared by reset.
- When undefined, the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- AUTO, 0xFFF00093 (addi x1,x0,-1), out_ready=1 → one cycle later out_imm=0xFFFFFFFF, fmt=000, err=0. With XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- AUTO back-to-back, one per cycle:
  - 0xFE112E23 (sw) → 0xFFFFFFFC, fmt 001.
  - 0x123452B7 (lui) → 0x12345000, fmt 100.
  - 0x001000EF (jal) → 0x00000800, fmt 011.
  - Results on consecutive cycles, in order.
- AUTO 0x002081B3 (add) → imm 0, fmt 111, err 0. AUTO 0x0000007F → err 1. Explicit 111 → err 1. With IMM_GEN_ERRCNT_EN, err_count=2.
- Backpressure: out_ready=0, offer 3 items with tags 1,2,3 → tags 1 and 2 accepted; in_ready=0 after the second accept; the third is held. Raise out_ready → tags 1,2,3 emerge in order, none lost or duplicated.
- Explicit Z, instr[19:15]=5'b11111 → out_imm=0x0000001F, fmt 110.
- Both entries full, assert reset for 1 cycle → next cycle out_valid=0, in_ready=1, and no stale item appears afterwards.
